// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults, an 800x600@60 alternate set,
// sync polarity encodings and a helper that sums one axis into its total period.
package vga_timing_pkg;

  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  // One axis of a video mode: visible region, front porch, sync pulse, back porch.
  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  // 640x480@60, 25 MHz pixel clock (100 MHz board clock / 4).
  localparam int           VGA640_CLK_DIV = 4;
  localparam axis_timing_t VGA640_H       = '{display: 640, front: 16, sync: 96, back: 48};
  localparam axis_timing_t VGA640_V       = '{display: 480, front: 10, sync: 2, back: 33};
  localparam int           VGA640_HS_POL  = POL_ACTIVE_LOW;
  localparam int           VGA640_VS_POL  = POL_ACTIVE_LOW;

  // 800x600@60, 40 MHz pixel clock (40 MHz board clock, no division).
  localparam int           SVGA800_CLK_DIV = 1;
  localparam axis_timing_t SVGA800_H       = '{display: 800, front: 40, sync: 128, back: 88};
  localparam axis_timing_t SVGA800_V       = '{display: 600, front: 1, sync: 4, back: 23};
  localparam int           SVGA800_HS_POL  = POL_ACTIVE_HIGH;
  localparam int           SVGA800_VS_POL  = POL_ACTIVE_HIGH;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel tick divider: counts system clocks while enabled and strobes p_tick
// on the last clock of every CLK_DIV-clock group.
module vga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             at_last;

  assign at_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = at_last ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Gating by reset_n keeps the strobe low while reset is held even when CLK_DIV=1.
  assign p_tick = reset_n & en & at_last;

endmodule

// File: rtl/vga_sync_param.sv
// Parametrised VGA sync generator: pixel tick divider, x/y position counters,
// registered hsync/vsync/video_on decode and line/frame start strobes.
module vga_sync_param
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = VGA640_CLK_DIV,
  parameter int H_DISPLAY = VGA640_H.display,
  parameter int H_FRONT   = VGA640_H.front,
  parameter int H_SYNC    = VGA640_H.sync,
  parameter int H_BACK    = VGA640_H.back,
  parameter int V_DISPLAY = VGA640_V.display,
  parameter int V_FRONT   = VGA640_V.front,
  parameter int V_SYNC    = VGA640_V.sync,
  parameter int V_BACK    = VGA640_V.back,
  parameter int HS_POL    = VGA640_HS_POL,
  parameter int VS_POL    = VGA640_VS_POL,
  parameter int COORD_W   = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam int H_TOTAL   = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL   = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int COORD_MAX = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_sync_param: CLK_DIV must be at least 1");
  end
  if ((COORD_MAX - 1) >= (1 << COORD_W)) begin : g_bad_coord_w
    $error("vga_sync_param: COORD_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic               HS_ACT   = (HS_POL != 0);
  localparam logic               VS_ACT   = (VS_POL != 0);

  function automatic logic hs_level(input logic [COORD_W-1:0] xv);
    return ((xv >= HS_FIRST) && (xv <= HS_LAST)) ? HS_ACT : ~HS_ACT;
  endfunction

  function automatic logic vs_level(input logic [COORD_W-1:0] yv);
    return ((yv >= VS_FIRST) && (yv <= VS_LAST)) ? VS_ACT : ~VS_ACT;
  endfunction

  function automatic logic vid_level(input logic [COORD_W-1:0] xv,
                                     input logic [COORD_W-1:0] yv);
    return (xv < H_VIS) && (yv < V_VIS);
  endfunction

  logic               tick;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               hsync_q, vsync_q, video_on_q;
  logic               line_start_q, frame_start_q;
  logic               line_wrap, frame_wrap;

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .p_tick  (tick)
  );

  assign line_wrap  = tick && (x_q == H_LAST);
  assign frame_wrap = line_wrap && (y_q == V_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (line_wrap) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decode from the next position so sync edges land on the same clock as x/y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= hs_level('0);
      vsync_q       <= vs_level('0);
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hs_level(x_d);
      vsync_q       <= vs_level(y_d);
      video_on_q    <= vid_level(x_d, y_d);
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign p_tick      = tick;
  // Strobes are suppressed whenever the generator is frozen.
  assign line_start  = line_start_q & en;
  assign frame_start = frame_start_q & en;

endmodule

// File: tb/tb_vga_sync_param.sv
// Self-checking bench for vga_sync_param: three configurations driven by one
// shared clock/reset/enable and compared every cycle against an arithmetic model.
module tb_vga_sync_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  // Instance A: 640x480 defaults.
  logic a_hs, a_vs, a_vo, a_pt, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  vga_sync_param u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .p_tick(a_pt), .line_start(a_ls), .frame_start(a_fs),
    .x(a_x), .y(a_y)
  );

  // Instance B: no division, active-high syncs.
  logic b_hs, b_vs, b_vo, b_pt, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  vga_sync_param #(.CLK_DIV(1), .HS_POL(1), .VS_POL(1)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .p_tick(b_pt), .line_start(b_ls), .frame_start(b_fs),
    .x(b_x), .y(b_y)
  );

  // Instance C: tiny raster so frame wraps and vsync occur many times.
  logic c_hs, c_vs, c_vo, c_pt, c_ls, c_fs;
  logic [3:0] c_x, c_y;
  vga_sync_param #(
    .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(0), .VS_POL(1), .COORD_W(4)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(c_hs), .vsync(c_vs),
    .video_on(c_vo), .p_tick(c_pt), .line_start(c_ls), .frame_start(c_fs),
    .x(c_x), .y(c_y)
  );

  typedef struct {
    int div, hd, hf, hs, hb, vd, vf, vs, vb, hp, vp;
  } cfg_t;

  cfg_t   cfg[3];
  longint e_cnt[3];   // enabled clocks since reset release
  bit     prev_t[3];  // last clock edge carried a pixel tick
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input string nm,
                            input logic hs, input logic vs, input logic vo,
                            input logic pt, input logic ls, input logic fs,
                            input logic [31:0] xo, input logic [31:0] yo);
    cfg_t   c;
    int     ht, vt, xe, ye;
    longint t;
    bit     pe, lse, fse, hse, vse, voe, hp, vp;
    c   = cfg[k];
    ht  = c.hd + c.hf + c.hs + c.hb;
    vt  = c.vd + c.vf + c.vs + c.vb;
    t   = e_cnt[k] / c.div;
    xe  = int'(t % ht);
    ye  = int'((t / ht) % vt);
    hp  = (c.hp != 0);
    vp  = (c.vp != 0);
    pe  = reset_n && en && ((e_cnt[k] % c.div) == c.div - 1);
    lse = reset_n && en && prev_t[k] && (xe == 0);
    fse = lse && (ye == 0);
    hse = (xe >= c.hd + c.hf && xe < c.hd + c.hf + c.hs) ? hp : !hp;
    vse = (ye >= c.vd + c.vf && ye < c.vd + c.vf + c.vs) ? vp : !vp;
    voe = (xe < c.hd) && (ye < c.vd);
    chk({nm, ".x"}, xo, 32'(xe));
    chk({nm, ".y"}, yo, 32'(ye));
    chk({nm, ".p_tick"}, 32'(pt), 32'(pe));
    chk({nm, ".line_start"}, 32'(ls), 32'(lse));
    chk({nm, ".frame_start"}, 32'(fs), 32'(fse));
    chk({nm, ".hsync"}, 32'(hs), 32'(hse));
    chk({nm, ".vsync"}, 32'(vs), 32'(vse));
    chk({nm, ".video_on"}, 32'(vo), 32'(voe));
  endtask

  task automatic check_all();
    check_inst(0, "A", a_hs, a_vs, a_vo, a_pt, a_ls, a_fs, 32'(a_x), 32'(a_y));
    check_inst(1, "B", b_hs, b_vs, b_vo, b_pt, b_ls, b_fs, 32'(b_x), 32'(b_y));
    check_inst(2, "C", c_hs, c_vs, c_vo, c_pt, c_ls, c_fs, 32'(c_x), 32'(c_y));
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      e_cnt[k]  = 0;
      prev_t[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        e_cnt[k]  = 0;
        prev_t[k] = 1'b0;
      end else begin
        prev_t[k] = en && ((e_cnt[k] % cfg[k].div) == cfg[k].div - 1);
        if (en) e_cnt[k]++;
      end
    end
  endtask

  // Drive inputs mid-cycle, check just after, then let the model follow the edge.
  task automatic step(input bit en_v, input bit rst_v);
    @(negedge clk);
    en = en_v;
    reset_n = rst_v;
    if (!rst_v) model_clear();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all();
  endtask

  function automatic int a_xpos();
    return int'((e_cnt[0] / 4) % 800);
  endfunction

  initial begin
    int guard;
    cfg[0] = '{div: 4, hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33, hp: 0, vp: 0};
    cfg[1] = '{div: 1, hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33, hp: 1, vp: 1};
    cfg[2] = '{div: 3, hd: 8, hf: 2, hs: 3, hb: 2, vd: 4, vf: 1, vs: 2, vb: 2, hp: 0, vp: 1};
    model_clear();

    // Reset held with en high: strobes must stay low, position at (0,0).
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Free run: more than one full default line, many small frames.
    for (int i = 0; i < 3300; i++) step(1'b1, 1'b1);

    // Freeze for 7 clocks at A.x==100 with the divider mid-count.
    guard = 0;
    while (!(a_xpos() == 100 && (e_cnt[0] % 4) == 2) && guard < 5000) begin
      step(1'b1, 1'b1);
      guard++;
    end
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3300; i++) step(1'b1, 1'b1);

    // Randomised enable pattern.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0, 1'b1);

    // Asynchronous reset between edges at A.x==400.
    guard = 0;
    while (a_xpos() != 400 && guard < 5000) begin
      step(1'b1, 1'b1);
      guard++;
    end
    async_reset_pulse();
    @(posedge clk);
    model_edge();
    step(1'b1, 1'b0);
    for (int i = 0; i < 800; i++) step($urandom_range(0, 4) != 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_param.md
Name: vga_sync_param

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Divides the system clock down to a pixel tick and runs horizontal and vertical position counters.
- Decodes hsync, vsync and video_on with configurable timing and polarity, and adds an enable input plus line-start and frame-start strobes.
- Sits between the board clock and the pixel/renderer logic (snake board drawing); x/y feed the pixel generator.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=1); 4 gives 25 MHz from 100 MHz
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- COORD_W, 10, width of x/y; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; low freezes the generator
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- p_tick  out  1  one-clk pixel strobe
- line_start  out  1  one-clk strobe when x wraps to 0
- frame_start  out  1  one-clk strobe when (x,y) wraps to (0,0)
- x  out  COORD_W  horizontal count, 0..H_TOTAL-1
- y  out  COORD_W  vertical count, 0..V_TOTAL-1

Behaviour:
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Reset (reset_n low, async): divider=0, x=0, y=0, p_tick=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL, video_on=1. Outputs are consistent with position (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - p_tick=1 for exactly one clk when div_cnt==CLK_DIV-1 and en=1.
  - With CLK_DIV=1, p_tick equals en.
- Horizontal counter: on the clk edge where p_tick=1, x increments; if x==H_TOTAL-1 it wraps to 0 and y advances.
- Vertical counter: y increments on a line wrap; if y==V_TOTAL-1 it wraps to 0.
- hsync = HS_POL when H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1; ~HS_POL otherwise. vsync is analogous using y and the V params.
- Output registration:
  - hsync, vsync and video_on are registered.
  - They are computed from the next x/y values so they change on the same edge as x/y.
  - Zero-cycle skew between x/y and the decoded signals; no combinational glitches on hsync/vsync.
- line_start: registered, high for the one clk immediately after the edge on which x became 0.
- frame_start: as line_start, but only when y also became 0. frame_start implies line_start.
- en=0:
  - div_cnt, x, y and all decoded outputs hold.
  - p_tick, line_start and frame_start are 0.
  - Resuming continues from the held div_cnt; no tick is lost or duplicated.
- Reset mid-frame: immediate return to reset values. After release, the first p_tick arrives CLK_DIV clks after the first en=1 clk.
- No parameter sanity checks in RTL beyond an elaboration-time error if COORD_W is too narrow or CLK_DIV<1.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 default constants
  - an H_TOTAL/V_TOTAL helper function
  - the polarity localparams
  - a 800x600 alternate constant set
- One sub-module: vga_tick_div (CLK_DIV divider with en, producing p_tick).
- Counters and decode stay in the top module.

Test Plan:
- Defaults, 100 MHz clk, reset released, en=1: p_tick is period 4 clks; line_start every 3200 clks; frame_start every 1,680,000 clks.
- hsync window: hsync goes low when x becomes 656 and high when x becomes 752 (96 ticks). vsync is low for y=490..491.
- video_on is 1 for x=639,y=479 and 0 at x=640 and y=480. At wrap x=799->0 with y=524, x=0,y=0 and frame_start=1 for exactly one clk.
- HS_POL=1, VS_POL=1, CLK_DIV=1: p_tick is constantly high. hsync is high only for x=656..751; reset value of hsync is 0.
- Drop en for 7 clks at x=100: x and div_cnt hold, with no p_tick. After en returns, x reaches 101 after the remaining div clks; the total tick count over one line is still 800.
- Assert reset_n low at x=400,y=200 asynchronously between edges: outputs return immediately to x=0,y=0, hsync/vsync inactive, strobes 0.
